// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - instruction-memory request/ack bus between fetch unit and imem
interface ifu_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: PC, variable-latency imem fetch, next-PC select
// A fetch timeout or a misaligned next PC latches fetch_err and parks the unit in HALT.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          TIMEOUT  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   ifu_fetch_if.master        imem,
   output logic [31:0]        instr,
   output logic [5:0]         opcode,
   output logic [5:0]         funct,
   output logic               instr_valid,
   output logic [31:0]        pc,
   output logic [31:0]        pc_plus4,
   input  logic [2:0]         npc_sel,
   input  logic               br_eq,
   input  logic               br_ge,
   input  logic [31:0]        rs_data,
   input  logic               adv,
   output logic               fetch_err
);
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {S_BOOT, S_FETCH, S_ISSUE, S_HALT} state_t;

   state_t        r_state, w_state_nxt;
   logic [31:0]   r_pc, r_instr;
   logic [CW-1:0] r_cnt;
   logic          r_err;
   logic [31:0]   w_next_pc, w_br_target;
   logic          w_timeout, w_misalign;

   assign pc_plus4    = r_pc + 32'd4;
   assign w_br_target = pc_plus4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
   assign w_timeout   = (r_cnt == CW'(TIMEOUT - 1));
   assign w_misalign  = |w_next_pc[1:0];

   always_comb begin
      w_next_pc = pc_plus4;
      case (npc_sel)
         3'b001:         if (br_eq) w_next_pc = w_br_target;
         3'b010, 3'b011: w_next_pc = {pc_plus4[31:28], r_instr[25:0], 2'b00};
         3'b100:         w_next_pc = rs_data;
         3'b101:         if (br_ge) w_next_pc = w_br_target;
         default:        w_next_pc = pc_plus4;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_BOOT;
      else        r_state <= w_state_nxt;
   end

   // Ack takes priority over timeout when both land on the same edge.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_BOOT:  w_state_nxt = S_FETCH;
         S_FETCH: begin
            if (imem.imem_ack)  w_state_nxt = S_ISSUE;
            else if (w_timeout) w_state_nxt = S_HALT;
         end
         S_ISSUE: if (adv) w_state_nxt = w_misalign ? S_HALT : S_FETCH;
         S_HALT:  w_state_nxt = S_HALT;
         default: w_state_nxt = S_HALT;
      endcase
   end

   always_comb begin
      imem.imem_req = 1'b0;
      instr_valid   = 1'b0;
      case (r_state)
         S_FETCH: imem.imem_req = 1'b1;
         S_ISSUE: instr_valid   = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc    <= RESET_PC;
         r_instr <= 32'd0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (imem.imem_ack) begin
                  r_instr <= imem.imem_rdata;
                  r_cnt   <= '0;
               end else if (w_timeout) begin
                  r_err <= 1'b1;
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_ISSUE: begin
               if (adv) begin
                  if (w_misalign) r_err <= 1'b1;
                  else            r_pc  <= w_next_pc;
               end
            end
            default: ;
         endcase
      end
   end

   assign imem.imem_addr = r_pc;
   assign instr          = r_instr;
   assign opcode         = r_instr[31:26];
   assign funct          = r_instr[5:0];
   assign pc             = r_pc;
   assign fetch_err      = r_err;
endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch with an imem responder and next-PC model
module tb_ifu_fetch;
   localparam logic [31:0] RPC = 32'h0000_3000;
   localparam int          TO  = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr, pc, pc_plus4, rs_data;
   logic [5:0]  opcode, funct;
   logic        instr_valid, fetch_err, br_eq, br_ge, adv;
   logic [2:0]  npc_sel;
   int          checks = 0;
   int          errors = 0;

   ifu_fetch_if u_if();

   ifu_fetch #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .imem(u_if),
      .instr(instr), .opcode(opcode), .funct(funct), .instr_valid(instr_valid),
      .pc(pc), .pc_plus4(pc_plus4), .npc_sel(npc_sel), .br_eq(br_eq), .br_ge(br_ge),
      .rs_data(rs_data), .adv(adv), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   // Next PC derived directly from the ISA rules with plain integer arithmetic.
   function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [31:0] ins,
                                             input logic [2:0] sel, input logic eq, input logic ge,
                                             input logic [31:0] rs);
      logic [31:0] seq, off;
      seq = p + 32'd4;
      off = 32'(signed'(ins[15:0])) * 32'd4;
      case (sel)
         3'd1:       return eq ? seq + off : seq;
         3'd5:       return ge ? seq + off : seq;
         3'd2, 3'd3: return (seq & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
         3'd4:       return rs;
         default:    return seq;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; adv = 1'b0; npc_sel = 3'd0; br_eq = 1'b0; br_ge = 1'b0; rs_data = 32'd0;
      u_if.imem_ack = 1'b0; u_if.imem_rdata = 32'd0;
      step(); step();
      rst_n = 1'b1;
   endtask

   task automatic serve(input logic [31:0] data, input int lat);
      for (int i = 1; i < lat; i++) step();
      u_if.imem_ack = 1'b1; u_if.imem_rdata = data;
      step();
      u_if.imem_ack = 1'b0; u_if.imem_rdata = $urandom;
   endtask

   task automatic commit(input logic [2:0] sel, input logic eq, input logic ge, input logic [31:0] rs);
      npc_sel = sel; br_eq = eq; br_ge = ge; rs_data = rs; adv = 1'b1;
      step();
      adv = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; adv = 1'b0; npc_sel = 3'd0; br_eq = 1'b0; br_ge = 1'b0; rs_data = 32'd0;
      u_if.imem_ack = 1'b0; u_if.imem_rdata = 32'd0;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (u_if.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %h exp 0", u_if.imem_req); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %h exp 0", instr_valid); end
      checks++; if (pc !== RPC) begin errors++; $display("FAIL rst_pc got %h exp %h", pc, RPC); end
      checks++; if (instr !== 32'd0) begin errors++; $display("FAIL rst_instr got %h exp 0", instr); end
      checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL rst_err got %h exp 0", fetch_err); end
      step();
      rst_n = 1'b1;
      checks++; if (u_if.imem_req !== 1'b0) begin errors++; $display("FAIL boot_req got %h exp 0", u_if.imem_req); end
      step();
      checks++; if (u_if.imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %h exp 1", u_if.imem_req); end
      checks++; if (u_if.imem_addr !== RPC) begin errors++; $display("FAIL first_addr got %h exp %h", u_if.imem_addr, RPC); end
   endtask

   task automatic test_issue();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL pre_ack_valid got %h exp 0", instr_valid); end
      serve(32'h3C01_1234, 1);
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL issue_valid got %h exp 1", instr_valid); end
      checks++; if (opcode !== 6'h0F) begin errors++; $display("FAIL issue_opcode got %h exp 0f", opcode); end
      checks++; if (funct !== 6'h34) begin errors++; $display("FAIL issue_funct got %h exp 34", funct); end
      checks++; if (u_if.imem_req !== 1'b0) begin errors++; $display("FAIL issue_req got %h exp 0", u_if.imem_req); end
      checks++; if (pc_plus4 !== 32'h3004) begin errors++; $display("FAIL issue_pc4 got %h exp 3004", pc_plus4); end
      step();
      checks++; if (instr !== 32'h3C01_1234) begin errors++; $display("FAIL issue_hold got %h exp 3c011234", instr); end
      commit(3'd0, 1'b0, 1'b0, 32'd0);
      checks++; if (u_if.imem_addr !== 32'h3004) begin errors++; $display("FAIL seq_addr got %h exp 3004", u_if.imem_addr); end
      checks++; if (u_if.imem_req !== 1'b1) begin errors++; $display("FAIL seq_req got %h exp 1", u_if.imem_req); end
   endtask

   task automatic test_branch();
      logic [2:0]  sel [3] = '{3'd1, 3'd1, 3'd5};
      logic        tk  [3] = '{1'b1, 1'b0, 1'b1};
      logic [31:0] exp [3] = '{32'h2FFC, 32'h3004, 32'h2FFC};
      for (int k = 0; k < 3; k++) begin
         do_reset(); step();
         serve({6'h04, 10'h0, 16'hFFFE}, 2);
         // Drive the condition that is not selected the opposite way to catch a swapped flag.
         if (sel[k] == 3'd1) commit(sel[k], tk[k], ~tk[k], 32'd0);
         else                commit(sel[k], ~tk[k], tk[k], 32'd0);
         checks++; if (u_if.imem_addr !== exp[k]) begin errors++; $display("FAIL branch%0d got %h exp %h", k, u_if.imem_addr, exp[k]); end
      end
   endtask

   task automatic test_jal();
      do_reset(); step();
      serve(32'h0, 1);
      commit(3'd0, 1'b0, 1'b0, 32'd0);
      serve({6'h03, 26'h000_0C01}, 3);
      checks++; if (pc !== 32'h3004) begin errors++; $display("FAIL jal_pc got %h exp 3004", pc); end
      checks++; if (pc_plus4 !== 32'h3008) begin errors++; $display("FAIL jal_pc4 got %h exp 3008", pc_plus4); end
      commit(3'd2, 1'b1, 1'b1, 32'hFFFF_0000);
      checks++; if (u_if.imem_addr !== 32'h3004) begin errors++; $display("FAIL jal_target got %h exp 3004", u_if.imem_addr); end
   endtask

   task automatic test_misalign();
      do_reset(); step();
      serve(32'h0000_0008, 1);
      commit(3'd4, 1'b0, 1'b0, 32'h3002);
      checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL mis_err got %h exp 1", fetch_err); end
      checks++; if (pc !== RPC) begin errors++; $display("FAIL mis_pc got %h exp %h", pc, RPC); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mis_valid got %h exp 0", instr_valid); end
      u_if.imem_ack = 1'b1; adv = 1'b1; npc_sel = 3'd0;
      for (int i = 0; i < 4; i++) step();
      u_if.imem_ack = 1'b0; adv = 1'b0;
      checks++; if (u_if.imem_req !== 1'b0) begin errors++; $display("FAIL halt_req got %h exp 0", u_if.imem_req); end
      checks++; if (fetch_err !== 1'b1 || pc !== RPC) begin errors++; $display("FAIL halt_hold got err %h pc %h exp err 1 pc %h", fetch_err, pc, RPC); end
      rst_n = 1'b0;
      #1;
      checks++; if (fetch_err !== 1'b0 || pc !== RPC) begin errors++; $display("FAIL halt_rst got err %h pc %h exp err 0 pc %h", fetch_err, pc, RPC); end
   endtask

   task automatic test_timeout();
      do_reset(); step();
      for (int i = 0; i < TO - 1; i++) step();
      checks++; if (fetch_err !== 1'b0 || u_if.imem_req !== 1'b1) begin errors++; $display("FAIL to_early got err %h req %h exp err 0 req 1", fetch_err, u_if.imem_req); end
      step();
      checks++; if (fetch_err !== 1'b1 || u_if.imem_req !== 1'b0) begin errors++; $display("FAIL to_edge got err %h req %h exp err 1 req 0", fetch_err, u_if.imem_req); end
      do_reset(); step();
      serve(32'hA5A5_5A5A, TO);
      checks++; if (instr_valid !== 1'b1 || fetch_err !== 1'b0) begin errors++; $display("FAIL to_ack got valid %h err %h exp valid 1 err 0", instr_valid, fetch_err); end
      checks++; if (instr !== 32'hA5A5_5A5A) begin errors++; $display("FAIL to_instr got %h exp a5a55a5a", instr); end
   endtask

   task automatic test_async_reset();
      do_reset(); step();
      serve(32'hDEAD_BEEF, 1);
      commit(3'd0, 1'b0, 1'b0, 32'd0);
      u_if.imem_ack = 1'b1; u_if.imem_rdata = 32'h1234_5678;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (u_if.imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL async_out got req %h valid %h exp 0 0", u_if.imem_req, instr_valid); end
      checks++; if (pc !== RPC || instr !== 32'd0) begin errors++; $display("FAIL async_state got pc %h instr %h exp %h 0", pc, instr, RPC); end
      u_if.imem_ack = 1'b0;
      step();
      rst_n = 1'b1;
      checks++; if (u_if.imem_req !== 1'b0) begin errors++; $display("FAIL async_boot got %h exp 0", u_if.imem_req); end
      step();
      checks++; if (u_if.imem_req !== 1'b1 || u_if.imem_addr !== RPC) begin errors++; $display("FAIL async_refetch got req %h addr %h exp 1 %h", u_if.imem_req, u_if.imem_addr, RPC); end
   endtask

   task automatic test_wrap();
      do_reset(); step();
      serve(32'h1, 1);
      commit(3'd4, 1'b0, 1'b0, 32'hFFFF_FFFC);
      checks++; if (u_if.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_jr got %h exp fffffffc", u_if.imem_addr); end
      serve(32'h2, 2);
      checks++; if (pc_plus4 !== 32'd0) begin errors++; $display("FAIL wrap_pc4 got %h exp 0", pc_plus4); end
      commit(3'd6, 1'b1, 1'b1, 32'h10);
      checks++; if (u_if.imem_addr !== 32'd0 || fetch_err !== 1'b0) begin errors++; $display("FAIL wrap_seq got addr %h err %h exp 0 0", u_if.imem_addr, fetch_err); end
   endtask

   task automatic test_random_stream();
      logic [31:0] pc_m, data, rs, exp;
      logic [2:0]  sel;
      logic        eq, ge;
      int          lat, hold;
      do_reset(); step();
      pc_m = RPC;
      for (int n = 0; n < 40; n++) begin
         checks++; if (u_if.imem_req !== 1'b1 || u_if.imem_addr !== pc_m) begin errors++; $display("FAIL rnd%0d_fetch got req %h addr %h exp 1 %h", n, u_if.imem_req, u_if.imem_addr, pc_m); end
         data = $urandom;
         lat  = $urandom_range(1, 6);
         for (int i = 1; i < lat; i++) begin
            adv = 1'($urandom); npc_sel = 3'($urandom);
            step();
         end
         adv = 1'b0;
         u_if.imem_ack = 1'b1; u_if.imem_rdata = data;
         step();
         u_if.imem_ack = 1'b0;
         hold = $urandom_range(0, 2);
         for (int i = 0; i < hold; i++) begin
            u_if.imem_ack = 1'($urandom); u_if.imem_rdata = $urandom;
            step();
         end
         u_if.imem_ack = 1'b0;
         checks++; if (instr_valid !== 1'b1 || instr !== data) begin errors++; $display("FAIL rnd%0d_issue got valid %h instr %h exp 1 %h", n, instr_valid, instr, data); end
         checks++; if (opcode !== data[31:26] || funct !== data[5:0]) begin errors++; $display("FAIL rnd%0d_fields got %h %h exp %h %h", n, opcode, funct, data[31:26], data[5:0]); end
         checks++; if (pc !== pc_m || pc_plus4 !== pc_m + 32'd4) begin errors++; $display("FAIL rnd%0d_pc got %h %h exp %h", n, pc, pc_plus4, pc_m); end
         sel = 3'($urandom); eq = 1'($urandom); ge = 1'($urandom);
         rs  = $urandom & 32'hFFFF_FFFC;
         exp = model_npc(pc_m, data, sel, eq, ge, rs);
         commit(sel, eq, ge, rs);
         pc_m = exp;
      end
      checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL rnd_err got %h exp 0", fetch_err); end
   endtask

   initial begin
      test_reset();
      test_issue();
      test_branch();
      test_jal();
      test_misalign();
      test_timeout();
      test_async_reset();
      test_wrap();
      test_random_stream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end
endmodule
